// File: rtl/ioports_gen_pkg.sv
// Shared constants for the byte-serial I/O port bank: opcodes, FSM encoding and
// the default design identifier.
package ioports_pkg;

   localparam logic [2:0] CMD_RESET  = 3'b001;
   localparam logic [2:0] CMD_WRITE  = 3'b010;
   localparam logic [2:0] CMD_READ   = 3'b011;
   localparam logic [2:0] CMD_RDBACK = 3'b100;
   localparam logic [2:0] CMD_SET    = 3'b101;
   localparam logic [2:0] CMD_CLR    = 3'b110;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      SEND_WAIT = 2'd2,
      SEND_HOLD = 2'd3
   } state_t;

   localparam logic [31:0] HWID_DEFAULT = 32'h2016_1701;

endpackage

// File: rtl/ioports_gen_pulse_timer.sv
// Per-port down-counter for return-to-zero outputs; a restart reloads LEN.
module pulse_timer #(
   parameter int LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic expire
);

   localparam int CW = $clog2(LEN + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (start) begin
         count_reg <= CW'(LEN);
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   // Strobe during the last live cycle so the owner clears on the edge the count hits 0.
   assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/ioports_gen.sv
// Byte-serial I/O port bank: command FSM, word assembly/serialisation and the
// output port registers with optional return-to-zero timers.
module ioports_gen
   import ioports_pkg::*;
#(
   parameter int          NBYTES     = 4,
   parameter int          NIN        = 8,
   parameter int          NOUT       = 16,
   parameter logic [15:0] PULSE_MASK = 16'h8000,
   parameter int          PULSE_LEN  = 4,
   parameter logic [31:0] HWID       = HWID_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [7:0]               datain,
   input  logic                     ready,
   output logic                     enout,
   output logic [7:0]               dataout,
   input  logic [NIN*NBYTES*8-1:0]  in_bus,
   output logic [NOUT*NBYTES*8-1:0] out_bus
);

   localparam int             W      = 8 * NBYTES;
   localparam int             IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0]  LAST   = IW'(NBYTES - 1);
   localparam logic [W-1:0]   HWID_W = W'(HWID);

   state_t         state_reg, state_next;
   logic [IW-1:0]  idx_reg, idx_next;
   logic [2:0]     op_reg, op_next;
   logic [3:0]     addr_reg, addr_next;
   logic [W-1:0]   shift_reg, shift_next;
   logic [W-1:0]   snap_reg, snap_next;
   logic           enout_reg, enout_next;
   logic [7:0]     dout_reg, dout_next;

   logic [6:0]     cmd;
   logic [W-1:0]   collected;
   logic           wr_strobe;
   logic           clr_all;
   logic [W-1:0]   in_word  [16];
   logic [W-1:0]   out_word [16];
   logic [W-1:0]   out_reg  [NOUT];
   logic [NOUT-1:0] wr_hit;
   logic [NOUT-1:0] expire;

   assign cmd       = 7'(datain & 8'h7F);
   assign collected = (shift_reg << 8) | W'(datain);

   // Unmapped addresses read back the identifier, so the read muxes are always 16 wide.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_rdmux
         if (gi < NIN) begin : g_in
            assign in_word[gi] = in_bus[gi*W +: W];
         end else begin : g_in_id
            assign in_word[gi] = HWID_W;
         end
         if (gi < NOUT) begin : g_out
            assign out_word[gi] = out_reg[gi];
         end else begin : g_out_id
            assign out_word[gi] = HWID_W;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         op_reg    <= '0;
         addr_reg  <= '0;
         shift_reg <= '0;
         snap_reg  <= '0;
         enout_reg <= 1'b0;
         dout_reg  <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         op_reg    <= op_next;
         addr_reg  <= addr_next;
         shift_reg <= shift_next;
         snap_reg  <= snap_next;
         enout_reg <= enout_next;
         dout_reg  <= dout_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      op_next    = op_reg;
      addr_next  = addr_reg;
      shift_next = shift_reg;
      snap_next  = snap_reg;
      enout_next = enout_reg;
      dout_next  = dout_reg;
      wr_strobe  = 1'b0;
      clr_all    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load) begin
               op_next    = cmd[6:4];
               addr_next  = cmd[3:0];
               idx_next   = '0;
               shift_next = '0;
               case (cmd[6:4])
                  CMD_RESET: begin
                     clr_all    = 1'b1;
                     enout_next = 1'b0;
                  end
                  CMD_WRITE, CMD_SET, CMD_CLR: state_next = COLLECT;
                  CMD_READ: begin
                     snap_next  = in_word[cmd[3:0]];
                     state_next = SEND_WAIT;
                  end
                  CMD_RDBACK: begin
                     snap_next  = out_word[cmd[3:0]];
                     state_next = SEND_WAIT;
                  end
                  default: ;
               endcase
            end
         end
         COLLECT: begin
            if (load) begin
               shift_next = collected;
               if (idx_reg == LAST) begin
                  wr_strobe  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         SEND_WAIT: begin
            if (ready) begin
               dout_next  = snap_reg[W-1 -: 8];
               enout_next = 1'b1;
               state_next = SEND_HOLD;
            end
         end
         SEND_HOLD: begin
            if (!ready) begin
               enout_next = 1'b0;
               snap_next  = snap_reg << 8;
               if (idx_reg == LAST) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = SEND_WAIT;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A fresh write always beats a timer expiring on the same edge.
   generate
      for (genvar gi = 0; gi < NOUT; gi++) begin : g_port
         assign wr_hit[gi] = wr_strobe && (addr_reg == 4'(gi));

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               out_reg[gi] <= '0;
            end else if (clr_all) begin
               out_reg[gi] <= '0;
            end else if (wr_hit[gi]) begin
               case (op_reg)
                  CMD_WRITE: out_reg[gi] <= collected;
                  CMD_SET:   out_reg[gi] <= out_reg[gi] | collected;
                  default:   out_reg[gi] <= out_reg[gi] & ~collected;
               endcase
            end else if (expire[gi]) begin
               out_reg[gi] <= '0;
            end
         end

         if (PULSE_MASK[gi]) begin : g_pulse
            pulse_timer #(
               .LEN(PULSE_LEN)
            ) u_timer (
               .clk    (clk),
               .reset  (reset),
               .start  (wr_hit[gi]),
               .expire (expire[gi])
            );
         end else begin : g_hold
            assign expire[gi] = 1'b0;
         end

         assign out_bus[gi*W +: W] = out_reg[gi];
      end
   endgenerate

   assign enout   = enout_reg;
   assign dataout = dout_reg;

endmodule
